// File: rtl/qbert_input_pkg.sv
// Shared constants and types for the Q*bert player-input conditioning block.
package qbert_input_pkg;

  localparam logic [7:0] ScUp    = 8'h75;
  localparam logic [7:0] ScDown  = 8'h72;
  localparam logic [7:0] ScLeft  = 8'h6B;
  localparam logic [7:0] ScRight = 8'h74;
  localparam logic [7:0] ScP1    = 8'h16;
  localparam logic [7:0] ScP2    = 8'h1E;
  localparam logic [7:0] ScCoin1 = 8'h2E;
  localparam logic [7:0] ScCoin2 = 8'h36;
  localparam logic [7:0] ScTest1 = 8'h06;

  // Control vector indices; bits 0..7 line up with joystick_0 so they OR directly.
  localparam int unsigned CtlDown  = 0;
  localparam int unsigned CtlUp    = 1;
  localparam int unsigned CtlLeft  = 2;
  localparam int unsigned CtlRight = 3;
  localparam int unsigned CtlP1    = 4;
  localparam int unsigned CtlP2    = 5;
  localparam int unsigned CtlCoin2 = 6;
  localparam int unsigned CtlCoin1 = 7;
  localparam int unsigned CtlTest1 = 8;
  localparam int unsigned CtlTest2 = 9;
  localparam int unsigned NumCtl   = 10;

  localparam int unsigned Ip1P1    = 0;
  localparam int unsigned Ip1P2    = 1;
  localparam int unsigned Ip1Coin1 = 2;
  localparam int unsigned Ip1Coin2 = 3;
  localparam int unsigned Ip1Test2 = 6;
  localparam int unsigned Ip1Test1 = 7;

  localparam int unsigned Ip4Down  = 0;
  localparam int unsigned Ip4Up    = 1;
  localparam int unsigned Ip4Right = 2;
  localparam int unsigned Ip4Left  = 3;

  typedef enum logic [2:0] {DirNone, DirUp, DirDown, DirLeft, DirRight} dir_t;
  typedef enum logic [1:0] {CoinIdle, CoinPulse, CoinWaitRel} coin_t;

  function automatic dir_t pick_dir(input logic up, input logic down, input logic left,
                                    input logic right);
    if (up) return DirUp;
    if (down) return DirDown;
    if (left) return DirLeft;
    if (right) return DirRight;
    return DirNone;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// One-bit debouncer: the output flips after DEBOUNCE_MS consecutive disagreeing tick samples.
module input_debounce
  import qbert_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic deb_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       deb_q, deb_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (tick_i) begin
      if (raw_i == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q + 4'd1 == 4'(DEBOUNCE_MS)) begin
        cnt_d = '0;
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/qbert_input_ctrl.sv
// Merges joystick and PS/2 controls, debounces them, applies 4-way locking and coin shaping,
// and produces the IP1710 / IP4740 input bytes.
module qbert_input_ctrl
  import qbert_input_pkg::*;
#(
  parameter int unsigned CLK_KHZ     = 50000,
  parameter int unsigned DEBOUNCE_MS = 4,
  parameter int unsigned COIN_MS     = 100
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] joystick_0,
  input  logic [10:0] ps2_key,
  input  logic        test_mode,
  output logic [7:0]  IP1710,
  output logic [7:0]  IP4740
);

  localparam int unsigned DivW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;

  logic [DivW-1:0]   div_q;
  logic              tick;
  logic              tog_q, ps2_live_q, ps2_ev;
  logic [8:0]        key_q, key_d;
  logic [NumCtl-1:0] raw, deb;
  logic [3:0]        dir_deb, dir_prev_q, dir_rise;
  logic              active_held;
  dir_t              dir_q;
  logic [1:0]        coin_raw, coin_deb, coin_prev_q, coin_rise, coin_armed_q;
  coin_t             coin_st_q [2];
  logic [7:0]        coin_cnt_q [2];
  logic [7:0]        ip1710_q, ip4740_q;
  logic              unused_joy;

  assign unused_joy = ^joystick_0[15:8];

  assign tick = (div_q == DivW'(CLK_KHZ - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  // The toggle copy is captured in the first cycle after reset, so reset itself is never an event.
  assign ps2_ev = ps2_live_q && (ps2_key[10] != tog_q);

  always_comb begin
    key_d = key_q;
    if (ps2_ev) begin
      case ({ps2_key[8], ps2_key[7:0]})
        {1'b1, ScUp}:    key_d[CtlUp]    = ps2_key[9];
        {1'b1, ScDown}:  key_d[CtlDown]  = ps2_key[9];
        {1'b1, ScLeft}:  key_d[CtlLeft]  = ps2_key[9];
        {1'b1, ScRight}: key_d[CtlRight] = ps2_key[9];
        {1'b0, ScP1}:    key_d[CtlP1]    = ps2_key[9];
        {1'b0, ScP2}:    key_d[CtlP2]    = ps2_key[9];
        {1'b0, ScCoin1}: key_d[CtlCoin1] = ps2_key[9];
        {1'b0, ScCoin2}: key_d[CtlCoin2] = ps2_key[9];
        {1'b0, ScTest1}: key_d[CtlTest1] = ps2_key[9];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q      <= 1'b0;
      ps2_live_q <= 1'b0;
      key_q      <= '0;
    end else begin
      tog_q      <= ps2_key[10];
      ps2_live_q <= 1'b1;
      key_q      <= key_d;
    end
  end

  always_comb begin
    raw           = '0;
    raw[7:0]      = joystick_0[7:0] | key_q[7:0];
    raw[CtlTest1] = joystick_0[4] | key_q[CtlTest1];
    raw[CtlTest2] = ~test_mode;
  end

  for (genvar i = 0; i < NumCtl; i++) begin : g_deb
    input_debounce #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_deb (
      .clk_i (clk_sys),
      .rst_ni(reset_n),
      .tick_i(tick),
      .raw_i (raw[i]),
      .deb_o (deb[i])
    );
  end

  assign dir_deb  = deb[3:0];
  assign dir_rise = dir_deb & ~dir_prev_q;

  always_comb begin
    case (dir_q)
      DirUp:    active_held = dir_deb[CtlUp];
      DirDown:  active_held = dir_deb[CtlDown];
      DirLeft:  active_held = dir_deb[CtlLeft];
      DirRight: active_held = dir_deb[CtlRight];
      default:  active_held = 1'b1;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir_q      <= DirNone;
      dir_prev_q <= '0;
      ip4740_q   <= '0;
    end else begin
      dir_prev_q <= dir_deb;
      if (|dir_rise) begin
        dir_q <= pick_dir(dir_rise[CtlUp], dir_rise[CtlDown], dir_rise[CtlLeft],
                          dir_rise[CtlRight]);
      end else if (!active_held) begin
        dir_q <= pick_dir(dir_deb[CtlUp], dir_deb[CtlDown], dir_deb[CtlLeft],
                          dir_deb[CtlRight]);
      end
      ip4740_q <= '0;
      case (dir_q)
        DirUp:    ip4740_q[Ip4Up]    <= 1'b1;
        DirDown:  ip4740_q[Ip4Down]  <= 1'b1;
        DirLeft:  ip4740_q[Ip4Left]  <= 1'b1;
        DirRight: ip4740_q[Ip4Right] <= 1'b1;
        default: ;
      endcase
    end
  end

  assign coin_raw  = {raw[CtlCoin2], raw[CtlCoin1]};
  assign coin_deb  = {deb[CtlCoin2], deb[CtlCoin1]};
  assign coin_rise = coin_deb & ~coin_prev_q;

  // A coin only arms once its raw input has been seen low, so one held through reset never pulses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        coin_st_q[i]  <= CoinIdle;
        coin_cnt_q[i] <= '0;
      end
      coin_prev_q  <= '0;
      coin_armed_q <= '0;
    end else begin
      coin_prev_q  <= coin_deb;
      coin_armed_q <= coin_armed_q | ~coin_raw;
      for (int i = 0; i < 2; i++) begin
        case (coin_st_q[i])
          CoinIdle: begin
            if (coin_rise[i] && coin_armed_q[i]) begin
              coin_st_q[i]  <= CoinPulse;
              coin_cnt_q[i] <= 8'(COIN_MS);
            end
          end
          CoinPulse: begin
            if (coin_cnt_q[i] == 8'd0) begin
              coin_st_q[i] <= coin_deb[i] ? CoinWaitRel : CoinIdle;
            end else if (tick) begin
              coin_cnt_q[i] <= coin_cnt_q[i] - 8'd1;
            end
          end
          CoinWaitRel: begin
            if (!coin_deb[i]) coin_st_q[i] <= CoinIdle;
          end
          default: coin_st_q[i] <= CoinIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ip1710_q <= '0;
    end else begin
      ip1710_q           <= '0;
      ip1710_q[Ip1P1]    <= deb[CtlP1];
      ip1710_q[Ip1P2]    <= deb[CtlP2];
      ip1710_q[Ip1Coin1] <= (coin_st_q[0] == CoinPulse);
      ip1710_q[Ip1Coin2] <= (coin_st_q[1] == CoinPulse);
      ip1710_q[Ip1Test2] <= deb[CtlTest2];
      ip1710_q[Ip1Test1] <= deb[CtlTest1];
    end
  end

  assign IP1710 = ip1710_q;
  assign IP4740 = ip4740_q;

endmodule

// File: tb/tb_qbert_input_ctrl.sv
// Directed bench for qbert_input_ctrl at CLK_KHZ=10 (1 ms = 10 clocks).
module tb_qbert_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] joystick_0;
  logic [10:0] ps2_key;
  logic        test_mode;
  logic [7:0]  IP1710, IP4740;
  logic        ps2_tog;

  int n_checks = 0;
  int n_pass   = 0;

  qbert_input_ctrl #(
    .CLK_KHZ    (10),
    .DEBOUNCE_MS(4),
    .COIN_MS    (100)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .joystick_0(joystick_0),
    .ps2_key   (ps2_key),
    .test_mode (test_mode),
    .IP1710    (IP1710),
    .IP4740    (IP4740)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       name;
    logic [15:0] joy;
    logic        tm;
    logic [7:0]  exp1;
    logic [7:0]  exp4;
  } vec_t;

  vec_t vecs[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_ms(input int n);
    wait_cyc(10 * n);
  endtask

  task automatic ps2_send(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_tog = ~ps2_tog;
    ps2_key = {ps2_tog, pressed, ext, code};
  endtask

  // Observe one IP1710 bit for ms milliseconds: cycles high and number of rising edges.
  task automatic watch_bit(input int bitn, input int ms, output int hi, output int edges);
    logic prev;
    hi = 0;
    edges = 0;
    prev = IP1710[bitn];
    for (int i = 0; i < ms * 10; i++) begin
      wait_cyc(1);
      if (IP1710[bitn]) hi++;
      if (IP1710[bitn] && !prev) edges++;
      prev = IP1710[bitn];
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi, edges, cyc;

    vecs.push_back('{"idle",           16'h0000, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{"up",             16'h0002, 1'b1, 8'h00, 8'h02});
    vecs.push_back('{"up then right",  16'h000A, 1'b1, 8'h00, 8'h04});
    vecs.push_back('{"right released", 16'h0002, 1'b1, 8'h00, 8'h02});
    vecs.push_back('{"none",           16'h0000, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{"down",           16'h0001, 1'b1, 8'h00, 8'h01});
    vecs.push_back('{"down then left", 16'h0005, 1'b1, 8'h00, 8'h08});
    vecs.push_back('{"left kept",      16'h0004, 1'b1, 8'h00, 8'h08});
    vecs.push_back('{"none again",     16'h0000, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{"all four",       16'h000F, 1'b1, 8'h00, 8'h02});
    vecs.push_back('{"up dropped",     16'h000D, 1'b1, 8'h00, 8'h01});
    vecs.push_back('{"p1 test1",       16'h0010, 1'b1, 8'h81, 8'h00});
    vecs.push_back('{"p2",             16'h0020, 1'b1, 8'h02, 8'h00});
    vecs.push_back('{"test2 on",       16'h0000, 1'b0, 8'h40, 8'h00});
    vecs.push_back('{"test2 off",      16'h0000, 1'b1, 8'h00, 8'h00});

    joystick_0 = '0;
    test_mode  = 1'b1;
    ps2_tog    = 1'b1;
    ps2_key    = {1'b1, 1'b1, 1'b1, 8'h75};  // toggle already high during reset: no event
    reset_n    = 1'b0;
    wait_cyc(3);
    check8("reset IP1710", IP1710, 8'h00);
    check8("reset IP4740", IP4740, 8'h00);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      joystick_0 = vecs[i].joy;
      test_mode  = vecs[i].tm;
      wait_ms(6);
      check8({vecs[i].name, " IP1710"}, IP1710, vecs[i].exp1);
      check8({vecs[i].name, " IP4740"}, IP4740, vecs[i].exp4);
    end

    // Short coin glitch must not survive the debouncer.
    joystick_0 = 16'h0080;
    wait_ms(2);
    joystick_0 = 16'h0000;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      wait_cyc(1);
      if (IP1710 != 8'h00) hi++;
    end
    check_range("coin glitch cycles nonzero", hi, 0, 0);

    // Press / release latency for up.
    joystick_0 = 16'h0002;
    cyc = 0;
    while (IP4740 != 8'h02 && cyc < 100) begin
      wait_cyc(1);
      cyc++;
    end
    check8("press latency value", IP4740, 8'h02);
    check_range("press latency cycles", cyc, 30, 45);
    wait_ms(6);
    joystick_0 = 16'h0000;
    cyc = 0;
    while (IP4740 != 8'h00 && cyc < 100) begin
      wait_cyc(1);
      cyc++;
    end
    check8("release latency value", IP4740, 8'h00);
    check_range("release latency cycles", cyc, 30, 45);

    // Coin1 held 300 ms: one 100 ms pulse; then again after a release.
    for (int n = 0; n < 2; n++) begin
      joystick_0 = 16'h0080;
      watch_bit(2, 300, hi, edges);
      check_range("coin1 pulse width", hi, 990, 1010);
      check_range("coin1 pulse count", edges, 1, 1);
      joystick_0 = 16'h0000;
      wait_ms(10);
    end
    joystick_0 = 16'h0040;
    watch_bit(3, 150, hi, edges);
    check_range("coin2 pulse width", hi, 990, 1010);
    check_range("coin2 pulse count", edges, 1, 1);
    joystick_0 = 16'h0000;
    wait_ms(10);

    // PS/2 keys.
    ps2_send(1'b1, 1'b1, 8'h75);
    wait_ms(6);
    check8("ps2 up press", IP4740, 8'h02);
    ps2_send(1'b0, 1'b1, 8'h75);
    wait_ms(6);
    check8("ps2 up release", IP4740, 8'h00);
    ps2_key = {ps2_tog, 1'b1, 1'b1, 8'h75};
    wait_ms(6);
    check8("ps2 no toggle", IP4740, 8'h00);
    ps2_send(1'b1, 1'b0, 8'h75);
    wait_ms(6);
    check8("ps2 non-ext 75 ignored", IP4740, 8'h00);
    ps2_send(1'b1, 1'b0, 8'h06);
    wait_ms(6);
    check8("ps2 F2 test1", IP1710, 8'h80);
    ps2_send(1'b0, 1'b0, 8'h06);
    wait_ms(6);
    check8("ps2 F2 release", IP1710, 8'h00);

    // Reset in the middle of a coin pulse.
    joystick_0 = 16'h0080;
    cyc = 0;
    while (!IP1710[2] && cyc < 100) begin
      wait_cyc(1);
      cyc++;
    end
    check8("coin before reset", IP1710, 8'h04);
    wait_ms(20);
    test_mode = 1'b0;
    reset_n   = 1'b0;
    #1;
    check8("reset aborts pulse", IP1710, 8'h00);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_ms(6);
    check8("test2 after reset", IP1710, 8'h40);
    watch_bit(2, 200, hi, edges);
    check_range("held coin no re-pulse", edges, 0, 0);
    joystick_0 = 16'h0000;
    wait_ms(10);
    joystick_0 = 16'h0080;
    watch_bit(2, 150, hi, edges);
    check_range("coin re-press pulse count", edges, 1, 1);
    check_range("coin re-press pulse width", hi, 990, 1010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qbert_input_ctrl.md
# qbert_input_ctrl

Conditions player controls for the Q*bert core and produces the two input-port bytes consumed by the mylstar board (IP1710 system/coin byte, IP4740 joystick byte). It merges the HPS joystick word with PS/2 keyboard events, debounces every control, applies last-pressed 4-way direction locking, and shapes coin inputs into fixed-width pulses. It sits between hps_io and mylstar_board in the top level.

## Interface
Parameters:
- CLK_KHZ, 50000, clk_sys frequency in kHz; sets the 1 ms tick divider.
- DEBOUNCE_MS, 4, consecutive agreeing 1 ms samples required to change a debounced bit (1..15).
- COIN_MS, 100, coin pulse width in ms (1..255).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- joystick_0  in  16  HPS joystick: [0] down, [1] up, [2] left, [3] right, [4] p1/test1, [5] p2, [6] coin2, [7] coin1.
- ps2_key  in  11  [10] toggle-on-event, [9] pressed, [8] extended, [7:0] scancode.
- test_mode  in  1  OSD test switch, active high.
- IP1710  out  8  {test1, test2, 0, 0, coin2, coin1, p2, p1}.
- IP4740  out  8  {0000, left, right, up, down}.

## Operation
- Key decode, active only on a ps2_key[10] change versus its registered copy: extended E075 up, E072 down, E06B left, E074 right; non-extended 16 p1, 1E p2, 2E coin1, 36 coin2, 06 test1. A matching event sets the key-state bit to ps2_key[9]. Other codes are ignored.
- Raw bit = joystick bit OR key-state bit. test1 raw = joystick_0[4] OR the F2 key. p1 raw = joystick_0[4] OR key 1.
- Debounce: 1 ms tick from a counter on 0..CLK_KHZ-1, pulsing at the wrap. On each tick, each raw bit is sampled. If the sample differs from the debounced value, a 4-bit per-bit counter increments; if it matches, the counter clears. The debounced bit flips when the counter reaches DEBOUNCE_MS, and the counter then clears.
- 4-way lock, states NONE/UP/DOWN/LEFT/RIGHT:
  - A debounced rising edge of a direction makes it active.
  - If several directions rise in the same cycle, priority is up>down>left>right.
  - When the active direction falls: if others are still held, the held one chosen by the same priority becomes active; otherwise the state goes to NONE.
  - IP4740 shows only the active direction, one-hot or zero.
- Coin shaper, one per coin, states IDLE/PULSE/WAIT_REL:
  - IDLE: a debounced rising edge goes to PULSE with the counter loaded to COIN_MS.
  - PULSE: the output is high and the counter decrements on each tick. At 0 it goes to WAIT_REL, or to IDLE if the input is already low.
  - WAIT_REL: goes to IDLE when the debounced input is low.
  - Rising edges during PULSE or WAIT_REL are ignored.
- test2 = ~test_mode (debounced). p1, p2 and test1 pass through debounced.

## Timing
- Reset (asynchronous assert, synchronous effect on release):
  - IP1710 = 8'h00, IP4740 = 8'h00.
  - Key states, debounced bits, counters and the tick divider are cleared.
  - The 4-way lock goes to NONE and the coin shapers go to IDLE.
  - The ps2 toggle copy loads ps2_key[10] so that no event is produced by reset.
- Output registers update one clk_sys after the internal state changes.
- Press latency from raw change to output: (DEBOUNCE_MS-1) to DEBOUNCE_MS ms + 2 clk_sys.
- The coin pulse is exactly COIN_MS ticks (±1 tick alignment).
- Reset asserted during a coin pulse aborts the pulse. After release, a still-held coin does not re-pulse until it has been released and pressed again.

## Structure
- Package qbert_input_pkg holds:
  - the scancode constants;
  - the bit indices for the IP1710 and IP4740 layouts;
  - the dir_t enum (NONE/UP/DOWN/LEFT/RIGHT);
  - the coin_t enum (IDLE/PULSE/WAIT_REL).
- One sub-module, input_debounce: per-bit counter, parameter DEBOUNCE_MS, inputs tick, raw and clock/reset, output debounced. It is instantiated once per control: 4 directions, 2 coins, p1, p2, test1, test2.
- The tick divider, key decoder, 4-way lock and coin shapers live in the top module.

## Test plan
Use CLK_KHZ=10 to shorten simulation.
- Hold joystick_0[1] for 10 ms → IP4740 = 8'h02 after 4 ms (±1 tick); release → 8'h00 after 4 ms.
- Press up, then right 10 ms later, then release right while up is still held → IP4740 goes 02 → 04 → 02.
- Press joystick_0[7] for 300 ms → IP1710[2] high for exactly 100 ticks, once. Release and press again → second 100-tick pulse.
- Raw coin glitches of 2 ms → no pulse and no debounced change.
- PS/2 event {toggle flip, pressed, ext, 75} → up is asserted. The same event with pressed=0 releases it. A repeated ps2_key word without a toggle flip → no change.
- Assert reset_n low mid coin pulse with coin held → IP1710 = 00 immediately. After release with coin still held, no pulse until the coin is released and pressed again. With test_mode=0, IP1710[6] = 1 after 4 ms.
